// File: rtl/shift_add_pkg.sv
// Shared definitions for the shift-add multiplier control: state encoding and default operand width.
package shift_add_pkg;

    localparam int N_BITS_DEFAULT = 8;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_LOAD  = 3'd1;
    localparam logic [2:0] ENC_ADD   = 3'd2;
    localparam logic [2:0] ENC_SHIFT = 3'd3;
    localparam logic [2:0] ENC_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_LOAD  = ENC_LOAD,
        ST_ADD   = ENC_ADD,
        ST_SHIFT = ENC_SHIFT,
        ST_DONE  = ENC_DONE
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_LOAD) || (s == ST_ADD) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/shift_add_control.sv
// Control FSM for the shift-add multiplier: load, per-bit add/shift, done pulse,
// with a saturating watchdog that aborts to IDLE and raises a sticky Err if K never arrives.
module shift_add_control
    import shift_add_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEFAULT,
    parameter int WD_MAX = 2 * N_BITS + 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    input  logic M,
    input  logic K,
    output logic Load,
    output logic Add,
    output logic Shift,
    output logic Busy,
    output logic Done,
    output logic Err
);

    localparam int              WD_W     = $clog2(WD_MAX + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WD_MAX);

    state_t          state;
    state_t          state_nxt;
    logic [WD_W-1:0] wd;
    logic            in_loop;
    logic            wd_trip;
    logic            add_en;

    // wd holds the number of ADD/SHIFT clocks already spent; this clock is the WD_MAX-th when wd == WD_MAX-1
    always_comb begin
        in_loop   = (state == ST_ADD) || (state == ST_SHIFT);
        wd_trip   = in_loop && (wd >= (WD_LIMIT - WD_W'(1)));
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = Start ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_nxt = ST_ADD;
            ST_ADD:   state_nxt = ST_SHIFT;
            ST_SHIFT: state_nxt = K ? ST_DONE : ST_ADD;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (wd_trip) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            wd     <= '0;
            Err    <= 1'b0;
            Load   <= 1'b0;
            add_en <= 1'b0;
            Shift  <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == ST_LOAD) begin
                wd <= '0;
            end else if (in_loop && (wd != WD_LIMIT)) begin
                wd <= wd + WD_W'(1);
            end

            if ((state == ST_IDLE) && Start) begin
                Err <= 1'b0;
            end else if (wd_trip) begin
                Err <= 1'b1;
            end

            // Outputs are registered copies of the decode of the state being entered
            Load   <= (state_nxt == ST_LOAD);
            add_en <= (state_nxt == ST_ADD);
            Shift  <= (state_nxt == ST_SHIFT);
            Busy   <= is_busy(state_nxt);
            Done   <= (state_nxt == ST_DONE);
        end
    end

    // M is the live multiplier LSB, so the add decision must see it in the ADD cycle itself
    assign Add = add_en & M;

endmodule
